// File: rtl/c_dot4_sink_pkg.sv
// Shared defaults and the result record for the complex dot-product path.
package c_dot4_sink_pkg;

  localparam int C_N     = 16;
  localparam int C_LAT   = 5;
  localparam int C_DEPTH = 4;
  localparam int IDX_W   = 8;

  typedef struct packed {
    logic signed [C_N-1:0] r;
    logic signed [C_N-1:0] i;
    logic [IDX_W-1:0]      idx;
  } entry_t;

endpackage

// File: rtl/c_sync_fifo.sv
// Synchronous FIFO with a registered head and an occupancy count; one-cycle write-to-head latency.
// Writes into a full FIFO are refused unless a read happens in the same cycle.
module c_sync_fifo
  import c_dot4_sink_pkg::*;
#(
  parameter type T     = entry_t,
  parameter int  DEPTH = C_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  T            wr_dat,
  output logic        full,
  input  logic        rd_en,
  output logic        rd_vld,
  output T            rd_dat,
  output logic [AW:0] level
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          push;
  logic          pop;

  assign rd_vld = (level != '0);
  assign full   = (level == (AW+1)'(DEPTH));
  assign pop    = rd_en && rd_vld;
  assign push   = wr_en && (!full || pop);
  assign rd_nxt = rd_ptr + AW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rd_dat <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_nxt;
      level  <= level + (AW+1)'(push) - (AW+1)'(pop);
      // A write landing in the slot that becomes the head must be forwarded
      // into the head register, since mem is only updated at this same edge.
      rd_dat <= (push && (rd_nxt == wr_ptr)) ? wr_dat : mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

endmodule

// File: rtl/c_dot4_sink.sv
// Collects every 4th valid MAC window sum into a result FIFO tagged with a group index.
// Push lands LAT cycles after the 4th mac_en; a full FIFO without a pop drops the result.
module c_dot4_sink
  import c_dot4_sink_pkg::*;
#(
  parameter int N     = C_N,
  parameter int LAT   = C_LAT,
  parameter int DEPTH = C_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mac_en,
  input  logic signed [N-1:0]     in_r,
  input  logic signed [N-1:0]     in_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [N-1:0]     out_r,
  output logic signed [N-1:0]     out_i,
  output logic [7:0]              out_idx,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    err_gap,
  output logic                    err_ovf,
  output logic                    busy
);

  logic [LAT-1:0] dl;
  logic [1:0]     wc;
  logic [7:0]     grp_idx;
  logic           pv;
  logic           grp_done;
  logic           pop;
  logic           fifo_full;
  entry_t         push_dat;
  entry_t         head;

  assign pv       = dl[LAT-1];
  assign grp_done = pv && (wc == 2'd3) && !start;
  assign pop      = out_valid && out_ready;
  assign busy     = (dl != '0) || (wc != 2'd0);
  assign push_dat = '{r: in_r, i: in_i, idx: grp_idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl      <= '0;
      wc      <= '0;
      grp_idx <= '0;
      err_gap <= 1'b0;
      err_ovf <= 1'b0;
    end else if (start) begin
      dl      <= '0;
      wc      <= '0;
      grp_idx <= '0;
      err_gap <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      dl <= (dl << 1) | LAT'(mac_en);
      if (pv) begin
        // wc wraps 3 -> 0 on group completion
        wc <= wc + 2'd1;
        if (wc == 2'd3) begin
          grp_idx <= grp_idx + 8'd1;
          if (fifo_full && !pop) begin
            err_ovf <= 1'b1;
          end
        end
      end else if (wc != 2'd0) begin
        wc      <= '0;
        err_gap <= 1'b1;
      end
    end
  end

  c_sync_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (grp_done),
    .wr_dat (push_dat),
    .full   (fifo_full),
    .rd_en  (out_ready),
    .rd_vld (out_valid),
    .rd_dat (head),
    .level  (fifo_level)
  );

  assign out_r   = head.r;
  assign out_i   = head.i;
  assign out_idx = head.idx;

endmodule

// File: doc/c_dot4_sink.md
C_DOT4_SINK -- requirements
Module: c_dot4_sink

Interface
REQ-001 Parameters: N, 16, total sample width; LAT, 5, mac_en-to-product latency of the upstream complex MAC; DEPTH, 4, output FIFO entries (power of two).
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle pulse; clears alignment state, group index and error flags.
REQ-005 mac_en  input  1  same strobe driven to the upstream MAC; 1 = operand pair presented this cycle.
REQ-006 in_r, in_i  input  N each, signed  upstream 4-tap window sum (real/imag), combinational from the MAC.
REQ-007 out_valid  output  1  FIFO head holds a result.
REQ-008 out_ready  input  1  consumer accepts head when out_valid=1.
REQ-009 out_r, out_i  output  N each, signed  FIFO head result.
REQ-010 out_idx  output  8  group index of FIFO head.
REQ-011 fifo_level  output  clog2(DEPTH)+1  stored entries.
REQ-012 err_gap, err_ovf  output  1 each  sticky error flags.
REQ-013 busy  output  1  any delay-line bit set or window count nonzero.

Function
REQ-014 Valid delay line of LAT stages; pv = mac_en delayed LAT cycles, marking cycles in which in_r/in_i include a valid product.
REQ-015 Window counter wc (0..3): pv=1 with wc<3 -> wc+1; pv=1 with wc=3 -> group complete, wc=0.
REQ-016 Group complete: in_r/in_i sampled that cycle pushed to FIFO with current group index; index increments by 1 modulo 256.
REQ-017 Gap: pv=0 with wc in 1..3 -> partial group discarded, wc=0, err_gap=1, index unchanged.
REQ-018 pv=0 with wc=0 -> no action.
REQ-019 Latency: mac_en of 4th sample in cycle c -> push at end of cycle c+LAT -> out_valid=1 in cycle c+LAT+1 if FIFO was empty.
REQ-020 Pop when out_valid and out_ready; head registered, no combinational path from out_ready to out_r/out_i.
REQ-021 Full FIFO + group complete + no pop same cycle -> result dropped, err_ovf=1, index still increments.
REQ-022 Full FIFO + group complete + pop same cycle -> pop and push both performed, level unchanged.
REQ-023 Empty FIFO + push: no bypass; out_valid rises the following cycle.
REQ-024 Pointers wrap modulo DEPTH; level never exceeds DEPTH nor underflows.
REQ-025 start: delay line, wc, index, err_gap, err_ovf cleared next cycle; FIFO contents kept.
REQ-026 start coincident with group complete -> start wins, no push, no index increment.
REQ-027 No arithmetic on samples; in_r/in_i stored bit-exact.

Reset
REQ-028 rst asserted: delay line 0, wc 0, index 0, pointers 0, out_valid 0, out_r/out_i 0, out_idx 0, fifo_level 0, err_gap 0, err_ovf 0, busy 0.
REQ-029 rst mid-group or with FIFO non-empty discards all state; first group after release counts from index 0.
REQ-030 mac_en asserted in the first cycle after rst release is accepted.

Structure
REQ-031 Shared package holds N, LAT, DEPTH defaults and the FIFO entry record type {r, i, idx}, common with the MAC stage.
REQ-032 FIFO is one sub-module, c_sync_fifo (registered output, level output); control logic stays in c_dot4_sink.

Verification
REQ-033 mac_en=1 cycles 0-3, in_r=0x0800, in_i=0xFF00 held -> out_valid cycle 9, out_r=0x0800, out_i=0xFF00, out_idx=0.
REQ-034 mac_en=1 cycles 0-1, 0 cycle 2, 1 cycles 3-6 -> err_gap=1 from cycle 8, one result, out_idx=0.
REQ-035 out_ready=0, 5 back-to-back groups (20 mac_en cycles) -> fifo_level=4, err_ovf=1, out_idx at head 0..3 on drain, next group gets idx 5.
REQ-036 FIFO full, out_ready=1 in push cycle -> level stays 4, err_ovf=0.
REQ-037 start in the cycle the 4th pv arrives -> no push, index 0, err flags 0, busy 0 next cycle.
REQ-038 rst pulse after 2 valid products -> all outputs 0; fresh 4-sample group afterwards yields out_idx=0.
